// File: rtl/ets_hit_accumulator_pkg.sv
// Shared types and default widths for the ETS comparator hit accumulator.
package ets_pkg;

  localparam int DEF_WIN_W    = 24;
  localparam int DEF_SETTLE_W = 8;
  localparam int DEF_TAG_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } ets_state_e;

endpackage

// File: rtl/ets_hit_accumulator_if.sv
// MCU-facing control and result handshake of the hit accumulator.
interface ets_hit_accumulator_if
  import ets_pkg::*;
#(
  parameter int WIN_W    = DEF_WIN_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int TAG_W    = DEF_TAG_W
);

  logic                start;
  logic                abort;
  logic [WIN_W-1:0]    window_len;
  logic [SETTLE_W-1:0] settle_len;
  logic                busy;
  logic [WIN_W-1:0]    hit_count;
  logic [TAG_W-1:0]    result_tag;
  logic                result_valid;
  logic                result_ready;
  logic                start_err;

  modport master (
    output start, abort, window_len, settle_len, result_ready,
    input  busy, hit_count, result_tag, result_valid, start_err
  );

  modport slave (
    input  start, abort, window_len, settle_len, result_ready,
    output busy, hit_count, result_tag, result_valid, start_err
  );

endinterface

// File: rtl/ets_hit_accumulator_down_counter.sv
// Loadable saturating down-counter; last_o is high while the count is zero.
module ets_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ets_hit_accumulator.sv
// Counts comparator hits over a window after a settling interval for one
// MMCM phase point and hands the count to the MCU with a wrapping tag.
module ets_hit_accumulator
  import ets_pkg::*;
#(
  parameter int WIN_W    = DEF_WIN_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                  shifting_clk,
  input  logic                  free_run_rst_n,
  input  logic                  cmp_sample,
  ets_hit_accumulator_if.slave  bus
);

  ets_state_e       state_q;
  logic             s_q;
  logic [WIN_W-1:0] acc_q;
  logic [WIN_W-1:0] hit_count_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;
  logic             busy_q;
  logic             start_err_q;
  logic             win_zero_q;

  logic             handshake;
  logic             accept;
  logic             start_err_d;
  logic             settle_last;
  logic             win_last;
  logic [WIN_W-1:0] acc_d;

  assign handshake   = (state_q == ST_DONE) && valid_q && bus.result_ready;
  assign accept      = bus.start && !bus.abort && ((state_q == ST_IDLE) || handshake);
  assign start_err_d = bus.start && !bus.abort && !accept;
  assign acc_d       = acc_q + WIN_W'(s_q);

  // SETTLE runs settle_len+1 cycles: the extra cycle lines the window up with
  // the s_q register, so the counted samples are those at edges S+1..S+W.
  ets_down_counter #(.CNT_W(SETTLE_W)) u_settle_cnt (
    .clk_i      (shifting_clk),
    .rst_ni     (free_run_rst_n),
    .clr_i      (bus.abort),
    .load_i     (accept),
    .load_val_i (bus.settle_len),
    .dec_i      (state_q == ST_SETTLE),
    .last_o     (settle_last)
  );

  ets_down_counter #(.CNT_W(WIN_W)) u_win_cnt (
    .clk_i      (shifting_clk),
    .rst_ni     (free_run_rst_n),
    .clr_i      (bus.abort),
    .load_i     (accept),
    .load_val_i (bus.window_len - WIN_W'(1)),
    .dec_i      (state_q == ST_ACCUM),
    .last_o     (win_last)
  );

  always_ff @(posedge shifting_clk or negedge free_run_rst_n) begin
    if (!free_run_rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= 1'b0;
      acc_q       <= '0;
      hit_count_q <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_err_q <= 1'b0;
      win_zero_q  <= 1'b0;
    end else begin
      s_q         <= cmp_sample;
      start_err_q <= start_err_d;
      if (bus.abort) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_last) begin
              if (win_zero_q) begin
                hit_count_q <= '0;
                valid_q     <= 1'b1;
                state_q     <= ST_DONE;
              end else begin
                state_q <= ST_ACCUM;
              end
            end
          end
          ST_ACCUM: begin
            acc_q <= acc_d;
            if (win_last) begin
              hit_count_q <= acc_d;
              valid_q     <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (handshake) begin
              valid_q <= 1'b0;
              tag_q   <= tag_q + TAG_W'(1);
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
        // A start taken in the handshake cycle skips IDLE entirely.
        if (accept) begin
          state_q    <= ST_SETTLE;
          busy_q     <= 1'b1;
          acc_q      <= '0;
          win_zero_q <= (bus.window_len == '0);
        end
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.result_tag   = tag_q;
  assign bus.result_valid = valid_q;
  assign bus.start_err    = start_err_q;

endmodule

// File: tb/tb_ets_hit_accumulator.sv
// Directed bench for ets_hit_accumulator: stimulus pushes expected results,
// a monitor pops and compares them on every result handshake.
module tb_ets_hit_accumulator;
  import ets_pkg::*;

  localparam int WW = DEF_WIN_W;
  localparam int SW = DEF_SETTLE_W;
  localparam int TW = DEF_TAG_W;

  typedef struct {
    logic [WW-1:0] hits;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmp   = 1'b0;
  int            n_pass  = 0;
  int            n_total = 0;
  exp_t          sb[$];
  logic [TW-1:0] tag_model = '0;
  logic          seen_valid;

  ets_hit_accumulator_if #(.WIN_W(WW), .SETTLE_W(SW), .TAG_W(TW)) bus_if ();

  ets_hit_accumulator #(.WIN_W(WW), .SETTLE_W(SW), .TAG_W(TW)) dut (
    .shifting_clk   (clk),
    .free_run_rst_n (rst_n),
    .cmp_sample     (cmp),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Sample pattern indexed by edge number relative to the accepted start.
  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return k[0];
      2:       return (k % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_meas(input int s, input int w, input int mode, input int exp_hits,
                          input logic rdy);
    @(negedge clk);
    bus_if.settle_len   = SW'(s);
    bus_if.window_len   = WW'(w);
    bus_if.start        = 1'b1;
    bus_if.result_ready = rdy;
    cmp                 = pat(mode, 0);
    @(posedge clk);
    sb.push_back('{hits: WW'(exp_hits), tag: tag_model});
    tag_model++;
    #1 chk("busy_after_start", 32'(bus_if.busy), 32'd1);
    for (int k = 1; k <= s + w + 1; k++) begin
      @(negedge clk);
      cmp = pat(mode, k);
      if (k == 1) begin
        bus_if.start      = 1'b0;
        bus_if.settle_len = ~SW'(s);
        bus_if.window_len = ~WW'(w);
      end
      @(posedge clk);
      #1;
      if (k == s + w)     chk("valid_early",   32'(bus_if.result_valid), 32'd0);
      if (k == s + w + 1) chk("valid_latency", 32'(bus_if.result_valid), 32'd1);
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus_if.result_valid && bus_if.result_ready && !bus_if.abort) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("hit_count",  32'(bus_if.hit_count),  32'(e.hits));
        chk("result_tag", 32'(bus_if.result_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.start        = 1'b0;
    bus_if.abort        = 1'b0;
    bus_if.result_ready = 1'b0;
    bus_if.window_len   = '0;
    bus_if.settle_len   = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy",      32'(bus_if.busy),         32'd0);
    chk("rst_valid",     32'(bus_if.result_valid), 32'd0);
    chk("rst_hit_count", 32'(bus_if.hit_count),    32'd0);
    chk("rst_tag",       32'(bus_if.result_tag),   32'd0);
    chk("rst_start_err", 32'(bus_if.start_err),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Constant ones, no settle; then alternating with settle; then empty window.
    run_meas(0, 16, 0, 16, 1'b1);
    @(posedge clk);
    #1;
    chk("busy_after_hs",  32'(bus_if.busy),         32'd0);
    chk("valid_after_hs", 32'(bus_if.result_valid), 32'd0);
    run_meas(4, 8, 1, 4, 1'b1);
    @(posedge clk);
    run_meas(3, 0, 0, 0, 1'b1);
    @(posedge clk);

    // Held result, ignored start, then start in the handshake cycle.
    run_meas(2, 5, 2, 2, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.window_len = WW'(77);
    bus_if.settle_len = SW'(9);
    @(posedge clk);
    #1 chk("start_err_pulse", 32'(bus_if.start_err), 32'd1);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(posedge clk);
    #1 chk("start_err_clear", 32'(bus_if.start_err), 32'd0);
    repeat (14) @(posedge clk);
    #1;
    chk("hold_hits",  32'(bus_if.hit_count),    32'd2);
    chk("hold_tag",   32'(bus_if.result_tag),   32'd3);
    chk("hold_valid", 32'(bus_if.result_valid), 32'd1);
    run_meas(1, 3, 0, 3, 1'b1);
    @(posedge clk);

    // Abort mid-ACCUM together with a start that must be dropped silently.
    @(negedge clk);
    bus_if.settle_len = '0;
    bus_if.window_len = WW'(100);
    bus_if.start      = 1'b1;
    cmp               = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (48) @(posedge clk);
    @(negedge clk);
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",      32'(bus_if.busy),         32'd0);
    chk("abort_valid",     32'(bus_if.result_valid), 32'd0);
    chk("abort_start_err", 32'(bus_if.start_err),    32'd0);
    chk("abort_hits_held", 32'(bus_if.hit_count),    32'd3);
    chk("abort_tag_held",  32'(bus_if.result_tag),   32'd5);
    @(negedge clk);
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    seen_valid = 1'b0;
    repeat (120) begin
      @(posedge clk);
      #1;
      if (bus_if.result_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);
    run_meas(2, 10, 1, 5, 1'b1);
    @(posedge clk);

    // 256 measurements carry the tag all the way round.
    for (int i = 0; i < 256; i++) begin
      run_meas(0, 1, 0, 1, 1'b1);
      @(posedge clk);
    end
    #1 chk("tag_wrap", 32'(bus_if.result_tag), 32'(tag_model));

    // Asynchronous reset in the middle of a long settle.
    @(negedge clk);
    bus_if.settle_len = SW'(200);
    bus_if.window_len = WW'(5);
    bus_if.start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy",      32'(bus_if.busy),         32'd0);
    chk("arst_valid",     32'(bus_if.result_valid), 32'd0);
    chk("arst_hit_count", 32'(bus_if.hit_count),    32'd0);
    chk("arst_tag",       32'(bus_if.result_tag),   32'd0);
    chk("arst_start_err", 32'(bus_if.start_err),    32'd0);
    tag_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_meas(1, 2, 0, 2, 1'b1);
    @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
